// File: rtl/periodic_task_scheduler.sv
// Periodic task scheduler: prescaled base tick, NUM_CH programmable periodic
// channels, and a round-robin grant of due channels to one shared resource.

module periodic_task_scheduler_ch #(
  parameter int PERIOD_W = 16,
  parameter int OVR_W    = 8
) (
  input  logic                clk,
  input  logic                reset_asyn,
  input  logic                tick,
  input  logic                cfg_we,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                clr,
  output logic                pending,
  output logic [OVR_W-1:0]    ovr
);
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;
  logic                due;

  // a config write on the wrap cycle restarts the phase instead of firing
  assign due = tick && !cfg_we && (period != '0) && (cnt == period - PERIOD_W'(1));

  always_ff @(posedge clk or posedge reset_asyn) begin
    if (reset_asyn) begin
      period <= '0;
      cnt    <= '0;
    end else if (cfg_we) begin
      period <= cfg_period;
      cnt    <= '0;
    end else if (tick && (period != '0)) begin
      cnt <= due ? '0 : cnt + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_asyn) begin
    if (reset_asyn) begin
      pending <= 1'b0;
      ovr     <= '0;
    end else begin
      if (cfg_we && (cfg_period == '0)) pending <= 1'b0;
      else if (due)                     pending <= 1'b1;
      else if (clr)                     pending <= 1'b0;
      if (due && pending && !clr && (ovr != '1)) ovr <= ovr + OVR_W'(1);
    end
  end
endmodule

module periodic_task_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 1000,
  parameter int PERIOD_W = 16,
  parameter int OVR_W    = 8,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset_asyn,
  input  logic                    enable,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [PERIOD_W-1:0]     cfg_period,
  output logic                    tick,
  output logic                    req_valid,
  output logic [CH_W-1:0]         req_ch,
  input  logic                    req_ready,
  input  logic                    task_done,
  output logic                    busy,
  output logic [NUM_CH-1:0]       pending,
  output logic [NUM_CH*OVR_W-1:0] ovr_cnt
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;

  state_t            state, state_nxt;
  logic [PS_W-1:0]   pcnt;
  logic              tick_en;
  logic [CH_W-1:0]   last_grant, sel, idx;
  logic              found, accept;
  logic [NUM_CH-1:0] clr_vec;

  always_ff @(posedge clk or posedge reset_asyn) begin
    if (reset_asyn) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (pcnt == PS_W'(PRESCALE - 1)) begin
      pcnt <= '0;
      tick <= 1'b1;
    end else begin
      pcnt <= pcnt + PS_W'(1);
      tick <= 1'b0;
    end
  end

  // channel counters only advance while enabled, even on a trailing tick
  assign tick_en = tick && enable;
  assign accept  = (state == REQ) && req_ready;
  assign clr_vec = accept ? (NUM_CH'(1) << req_ch) : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    periodic_task_scheduler_ch #(
      .PERIOD_W (PERIOD_W),
      .OVR_W    (OVR_W)
    ) u_ch (
      .clk        (clk),
      .reset_asyn (reset_asyn),
      .tick       (tick_en),
      .cfg_we     (cfg_we && (cfg_ch == CH_W'(i))),
      .cfg_period (cfg_period),
      .clr        (clr_vec[i]),
      .pending    (pending[i]),
      .ovr        (ovr_cnt[i*OVR_W +: OVR_W])
    );
  end

  // round-robin scan starting just after the last granted channel
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:      if (found) state_nxt = REQ;
      REQ: begin
        req_valid = 1'b1;
        if (req_ready) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (task_done) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_asyn) begin
    if (reset_asyn) begin
      state      <= IDLE;
      req_ch     <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && found) req_ch <= sel;
      if (accept) last_grant <= req_ch;
    end
  end
endmodule
